// File: rtl/pwm_bank_if.sv
// Duty-cycle configuration bus for pwm_bank.
// Ports: cfg_we strobe, cfg_sel channel, cfg_duty value.
interface pwm_bank_if #(
  parameter int CW   = 5,
  parameter int SELW = 2
);
  logic            cfg_we;
  logic [SELW-1:0] cfg_sel;
  logic [CW-1:0]   cfg_duty;

  modport master (
    output cfg_we,
    output cfg_sel,
    output cfg_duty
  );

  modport slave (
    input cfg_we,
    input cfg_sel,
    input cfg_duty
  );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM with a shared frame counter.
// Duty and period writes are double-buffered and
// only take effect at frame wrap.
// Ports: clk, reset (sync, high), en (count enable),
//   period (next terminal count), cfg (duty bus),
//   pwm_out (per channel), count, tick (last count).
module pwm_bank #(
  parameter int NCH          = 4,
  parameter int CW           = 5,
  parameter int SELW         = 2,
  parameter int RESET_PERIOD = 24
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [CW-1:0]  period,
  pwm_bank_if.slave      cfg,
  output logic [NCH-1:0] pwm_out,
  output logic [CW-1:0]  count,
  output logic           tick
);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] per_q, per_d;
  logic [CW-1:0] pend_q [NCH];
  logic [CW-1:0] pend_d [NCH];
  logic [CW-1:0] act_q  [NCH];
  logic [CW-1:0] act_d  [NCH];
  logic          wrap;

  assign wrap  = en & (count_q == per_q);
  assign tick  = wrap;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    per_d   = per_q;
    pend_d  = pend_q;
    act_d   = act_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + CW'(1);
    end
    if (wrap) begin
      per_d = period;
      act_d = pend_q;
    end
    // Out-of-range selects match no channel.
    // A write landing on the wrap edge goes
    // straight to the active register too.
    for (int k = 0; k < NCH; k++) begin
      if (cfg.cfg_we &&
          cfg.cfg_sel == SELW'(k)) begin
        pend_d[k] = cfg.cfg_duty;
        if (wrap) begin
          act_d[k] = cfg.cfg_duty;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      per_q   <= CW'(RESET_PERIOD);
      for (int k = 0; k < NCH; k++) begin
        pend_q[k] <= '0;
        act_q[k]  <= '0;
      end
    end else begin
      count_q <= count_d;
      per_q   <= per_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
    end
  end

  // Compare of registered values only.
  always_comb begin
    pwm_out = '0;
    for (int k = 0; k < NCH; k++) begin
      pwm_out[k] = count_q < act_q[k];
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed self-checking bench for pwm_bank.
// Walks reset, duty, period, freeze and reset cases.
module tb_pwm_bank;
  localparam int NCH  = 4;
  localparam int CW   = 5;
  localparam int SELW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic [CW-1:0]  period;
  logic [NCH-1:0] pwm_out;
  logic [CW-1:0]  count;
  logic           tick;

  int n_chk = 0;
  int n_err = 0;
  int dact [NCH];

  pwm_bank_if #(.CW(CW), .SELW(SELW)) cfg ();

  pwm_bank #(
    .NCH(NCH), .CW(CW), .SELW(SELW),
    .RESET_PERIOD(24)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .period(period), .cfg(cfg),
    .pwm_out(pwm_out), .count(count),
    .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stepn(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int sel,
                    input int duty);
    cfg.cfg_we   = 1'b1;
    cfg.cfg_sel  = SELW'(sel);
    cfg.cfg_duty = CW'(duty);
    step();
    cfg.cfg_we   = 1'b0;
  endtask

  function automatic logic [31:0] pw(input int c);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) r[k] = c < dact[k];
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    en = 1'b0;
    period = 5'd24;
    cfg.cfg_we = 1'b0;
    cfg.cfg_sel = '0;
    cfg.cfg_duty = '0;
    for (int k = 0; k < NCH; k++) dact[k] = 0;
    stepn(2);
    chk("rst_count", 32'(count), 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_tick", 32'(tick), 0);
    reset = 1'b0;
    en = 1'b1;

    // 1: free run, 25-count frames
    for (int i = 0; i < 50; i++) begin
      chk("t1_count", 32'(count), i % 25);
      chk("t1_tick", 32'(tick), 32'(i % 25 == 24));
      chk("t1_pwm", 32'(pwm_out), 0);
      step();
    end

    // 2: ch1 duty 10 written mid-frame
    stepn(5);
    wr(1, 10);
    for (int i = 6; i < 25; i++) begin
      chk("t2_hold", 32'(pwm_out), 0);
      step();
    end
    dact[1] = 10;
    for (int i = 0; i < 25; i++) begin
      chk("t2_count", 32'(count), i);
      chk("t2_pwm", 32'(pwm_out), pw(i));
      step();
    end

    // 3: duty 0, >period, ==period
    wr(0, 0);
    wr(2, 25);
    wr(3, 24);
    stepn(22);
    dact[2] = 25;
    dact[3] = 24;
    for (int i = 0; i < 25; i++) begin
      chk("t3_pwm", 32'(pwm_out), pw(i));
      step();
    end

    // 4: period 7 late in frame, write on tick
    stepn(12);
    period = 5'd7;
    for (int i = 12; i < 24; i++) begin
      chk("t4_count", 32'(count), i);
      chk("t4_notick", 32'(tick), 0);
      step();
    end
    chk("t4_tick24", 32'(tick), 1);
    wr(3, 4);
    dact[3] = 4;
    for (int i = 0; i < 16; i++) begin
      chk("t4_count8", 32'(count), i % 8);
      chk("t4_tick8", 32'(tick), 32'(i % 8 == 7));
      chk("t4_pwm", 32'(pwm_out), pw(i % 8));
      step();
    end

    // 5: freeze at 15, bad select write
    period = 5'd24;
    stepn(8);
    stepn(15);
    chk("t5_at15", 32'(count), 15);
    en = 1'b0;
    cfg.cfg_we = 1'b1;
    cfg.cfg_sel = 3'd5;
    cfg.cfg_duty = 5'd31;
    for (int i = 0; i < 5; i++) begin
      step();
      cfg.cfg_we = 1'b0;
      chk("t5_count", 32'(count), 15);
      chk("t5_tick", 32'(tick), 0);
      chk("t5_pwm", 32'(pwm_out), pw(15));
    end
    en = 1'b1;
    step();
    chk("t5_resume", 32'(count), 16);
    stepn(9);
    for (int i = 0; i < 25; i++) begin
      chk("t5_sel5", 32'(pwm_out), pw(i));
      step();
    end

    // 6: reset mid-frame discards pending
    stepn(7);
    wr(0, 20);
    step();
    chk("t6_at9", 32'(pwm_out), pw(9));
    period = 5'd7;
    reset = 1'b1;
    step();
    chk("t6_count", 32'(count), 0);
    chk("t6_pwm", 32'(pwm_out), 0);
    chk("t6_tick", 32'(tick), 0);
    reset = 1'b0;
    for (int k = 0; k < NCH; k++) dact[k] = 0;
    for (int i = 0; i < 25; i++) begin
      chk("t6_count25", 32'(count), i);
      chk("t6_tick25", 32'(tick), 32'(i == 24));
      chk("t6_pwm0", 32'(pwm_out), 0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      chk("t6_count8", 32'(count), i);
      chk("t6_tick8", 32'(tick), 32'(i == 7));
      chk("t6_nopend", 32'(pwm_out), 0);
      step();
    end

    // 7: period 0, single-count frames
    period = 5'd0;
    stepn(8);
    for (int i = 0; i < 3; i++) begin
      chk("t7_count", 32'(count), 0);
      chk("t7_tick", 32'(tick), 1);
      step();
    end
    wr(2, 1);
    chk("t7_pwm", 32'(pwm_out), 32'h4);
    chk("t7_cnt", 32'(count), 0);
    en = 1'b0;
    #1;
    chk("t7_frz", 32'(tick), 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule
